// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACT,
    RD_DONE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } mem_state_t;

  localparam logic        STROBE_OFF = 1'b1;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned DATA_W     = 16;

endpackage

// File: rtl/tristate_buffer.sv
// Drives a bidirectional pad with d while sel is high, otherwise releases it.
module tristate_buffer #(
  parameter int unsigned W = 16
) (
  input  logic         sel,
  input  logic [W-1:0] d,
  inout  wire  [W-1:0] pad
);

  assign pad = sel ? d : {W{1'bz}};

endmodule

// File: rtl/sram_mem_ctrl.sv
// Single-outstanding-request sequencer for a 16-bit asynchronous SRAM.
// All pin strobes, address and bus drive enable come straight from flops.
module sram_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_be,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [15:0]       Data
);

  mem_state_t              state;
  logic [CNT_W-1:0]        cnt;
  logic                    drive_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    accept;

  assign accept = req_valid & req_ready;

  // Write data is pure datapath; only meaningful while drive_q is set.
  always_ff @(posedge Clk) begin
    if (accept) wdata_q <= req_wdata;
  end

  // Control FSM; strobes are updated on the same edge as the state they belong to.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      CE        <= STROBE_OFF;
      UB        <= STROBE_OFF;
      LB        <= STROBE_OFF;
      OE        <= STROBE_OFF;
      WE        <= STROBE_OFF;
      ADDR      <= '0;
      drive_q   <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            ADDR      <= req_addr;
            UB        <= ~req_be[1];
            LB        <= ~req_be[0];
            req_ready <= 1'b0;
            CE        <= 1'b0;
            if (req_we) begin
              state   <= WR_SETUP;
              drive_q <= 1'b1;
            end else begin
              state <= RD_ACT;
              cnt   <= CNT_W'(WAIT_STATES);
              OE    <= 1'b0;
            end
          end
        end
        RD_ACT: begin
          if (cnt == '0) begin
            rsp_rdata <= Data;
            state     <= RD_DONE;
            rsp_valid <= 1'b1;
            CE        <= STROBE_OFF;
            OE        <= STROBE_OFF;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RD_DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        WR_SETUP: begin
          state <= WR_PULSE;
          cnt   <= CNT_W'(WAIT_STATES);
          WE    <= 1'b0;
        end
        WR_PULSE: begin
          if (cnt == '0) begin
            state     <= WR_HOLD;
            WE        <= STROBE_OFF;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WR_HOLD: begin
          state     <= IDLE;
          CE        <= STROBE_OFF;
          drive_q   <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          CE        <= STROBE_OFF;
          OE        <= STROBE_OFF;
          WE        <= STROBE_OFF;
          drive_q   <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  tristate_buffer #(.W(DATA_W)) u_data_buf (
    .sel (drive_q),
    .d   (wdata_q),
    .pad (Data)
  );

endmodule
